// File: rtl/offset_commit_arbiter_if.sv
// Requester/offset-register bundle for offset_commit_arbiter.
// The master side is the pair of requesters; the slave side is the arbiter.
interface offset_commit_arbiter_if;
  logic       ReqA;
  logic [5:0] XA;
  logic [9:0] YA;
  logic       AckA;
  logic       ReqB;
  logic [5:0] XB;
  logic [9:0] YB;
  logic       AckB;
  logic [5:0] XOffsetData;
  logic [9:0] YOffsetData;
  logic       OffsetWrite;
  logic       Busy;

  modport master (
    output ReqA, XA, YA, ReqB, XB, YB,
    input  AckA, AckB, XOffsetData, YOffsetData, OffsetWrite, Busy
  );

  modport slave (
    input  ReqA, XA, YA, ReqB, XB, YB,
    output AckA, AckB, XOffsetData, YOffsetData, OffsetWrite, Busy
  );
endinterface

// File: rtl/offset_commit_arbiter.sv
// Grants one of two offset requesters and commits its X/Y after a full VSync high phase.
// Define OFFSET_ARB_RR_EN for round-robin ties; otherwise A has fixed priority.
module offset_commit_arbiter #(
  parameter int SETTLE_CYC = 1,
  parameter int WRITE_LEN  = 1
) (
  input logic PixelClk2,
  input logic Reset,
  input logic VSync,
  offset_commit_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    VS_HI,
    SETTLE,
    WRITE,
    DONE,
    HOLDOFF
  } state_t;

  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC > 0) ? 4'(SETTLE_CYC - 1) : 4'd0;
  localparam logic [3:0] WRITE_LAST  = 4'(WRITE_LEN);

  state_t     state;
  logic [3:0] cnt;
  logic [5:0] shadow_x;
  logic [9:0] shadow_y;
  logic       granted_b;
  logic [5:0] x_data;
  logic [9:0] y_data;
  logic       write;
  logic       ack_a;
  logic       ack_b;
  logic       busy;
  logic       pick_b;

`ifdef OFFSET_ARB_RR_EN
  logic favour_b;
  assign pick_b = bus.ReqB & (~bus.ReqA | favour_b);
`else
  assign pick_b = ~bus.ReqA;
`endif

  // WRITE spends its first cycle raising the strobe, so the strobe appears one
  // cycle after the state is entered and stays up for WRITE_LEN cycles.
  always_ff @(negedge PixelClk2) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow_x  <= '0;
      shadow_y  <= '0;
      granted_b <= 1'b0;
      x_data    <= '0;
      y_data    <= '0;
      write     <= 1'b0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      busy      <= 1'b0;
`ifdef OFFSET_ARB_RR_EN
      favour_b  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ReqA || bus.ReqB) begin
            granted_b <= pick_b;
            shadow_x  <= pick_b ? bus.XB : bus.XA;
            shadow_y  <= pick_b ? bus.YB : bus.YA;
            busy      <= 1'b1;
            state     <= ARMED;
`ifdef OFFSET_ARB_RR_EN
            favour_b  <= ~pick_b;
`endif
          end
        end
        ARMED: begin
          if (VSync) state <= VS_HI;
        end
        VS_HI: begin
          if (!VSync) begin
            cnt   <= '0;
            state <= (SETTLE_CYC == 0) ? WRITE : SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= WRITE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WRITE: begin
          if (cnt == 4'd0) begin
            x_data <= shadow_x;
            y_data <= shadow_y;
            write  <= 1'b1;
            cnt    <= 4'd1;
          end else if (cnt == WRITE_LAST) begin
            write <= 1'b0;
            ack_a <= ~granted_b;
            ack_b <= granted_b;
            state <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          state <= HOLDOFF;
        end
        HOLDOFF: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.XOffsetData = x_data;
  assign bus.YOffsetData = y_data;
  assign bus.OffsetWrite = write;
  assign bus.AckA        = ack_a;
  assign bus.AckB        = ack_b;
  assign bus.Busy        = busy;

endmodule

// File: tb/tb_offset_commit_arbiter.sv
// Frame-level scoreboard bench for offset_commit_arbiter: default instance and
// a SETTLE_CYC=0 / WRITE_LEN=3 instance share clock, reset and VSync.
module tb_offset_commit_arbiter;

  typedef struct {
    int         src;
    logic [5:0] x;
    logic [9:0] y;
    int         rise;
  } exp_t;

  logic clk;
  logic rst;
  logic vsync;

  logic       req_a [2];
  logic       req_b [2];
  logic [5:0] xa    [2];
  logic [5:0] xb    [2];
  logic [9:0] ya    [2];
  logic [9:0] yb    [2];
  logic       ow    [2];
  logic       ack_a [2];
  logic       ack_b [2];
  logic       busy  [2];
  logic [5:0] xo    [2];
  logic [9:0] yo    [2];

  offset_commit_arbiter_if bus0 ();
  offset_commit_arbiter_if bus1 ();

  offset_commit_arbiter #(.SETTLE_CYC(1), .WRITE_LEN(1)) dut0 (
    .PixelClk2(clk), .Reset(rst), .VSync(vsync), .bus(bus0)
  );

  offset_commit_arbiter #(.SETTLE_CYC(0), .WRITE_LEN(3)) dut1 (
    .PixelClk2(clk), .Reset(rst), .VSync(vsync), .bus(bus1)
  );

  assign bus0.ReqA = req_a[0];
  assign bus0.XA   = xa[0];
  assign bus0.YA   = ya[0];
  assign bus0.ReqB = req_b[0];
  assign bus0.XB   = xb[0];
  assign bus0.YB   = yb[0];
  assign bus1.ReqA = req_a[1];
  assign bus1.XA   = xa[1];
  assign bus1.YA   = ya[1];
  assign bus1.ReqB = req_b[1];
  assign bus1.XB   = xb[1];
  assign bus1.YB   = yb[1];

  assign ow[0]    = bus0.OffsetWrite;
  assign ack_a[0] = bus0.AckA;
  assign ack_b[0] = bus0.AckB;
  assign busy[0]  = bus0.Busy;
  assign xo[0]    = bus0.XOffsetData;
  assign yo[0]    = bus0.YOffsetData;
  assign ow[1]    = bus1.OffsetWrite;
  assign ack_a[1] = bus1.AckA;
  assign ack_b[1] = bus1.AckB;
  assign busy[1]  = bus1.Busy;
  assign xo[1]    = bus1.XOffsetData;
  assign yo[1]    = bus1.YOffsetData;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   quiet      = 1'b1;
  exp_t expq [2][$];
  logic [5:0] last_x [2];
  logic [9:0] last_y [2];

  // Reference model: pending requests, current requester data, who holds the grant.
  bit         pend  [2];
  logic [5:0] cur_x [2];
  logic [9:0] cur_y [2];
  int         armed = -1;
  logic [5:0] arm_x;
  logic [9:0] arm_y;
`ifdef OFFSET_ARB_RR_EN
  bit         favour_b = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) cyc <= cyc + 1;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int wlen_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every driver wait goes through here so requesters drop Req on their Ack.
  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ack_a[i] === 1'b1) req_a[i] = 1'b0;
        if (ack_b[i] === 1'b1) req_b[i] = 1'b0;
      end
    end
  endtask

  task automatic drive(input int s, input logic [5:0] x, input logic [9:0] y);
    cur_x[s] = x;
    cur_y[s] = y;
    for (int i = 0; i < 2; i++) begin
      if (s == 0) begin
        xa[i] = x;
        ya[i] = y;
      end else begin
        xb[i] = x;
        yb[i] = y;
      end
    end
  endtask

  task automatic raise(input int s, input logic [5:0] x, input logic [9:0] y);
    pend[s] = 1'b1;
    drive(s, x, y);
    for (int i = 0; i < 2; i++) begin
      if (s == 0) req_a[i] = 1'b1;
      else        req_b[i] = 1'b1;
    end
  endtask

  task automatic arbitrate();
    int w;
    if (armed < 0 && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) begin
`ifdef OFFSET_ARB_RR_EN
        w = favour_b ? 1 : 0;
`else
        w = 0;
`endif
      end else begin
        w = pend[0] ? 0 : 1;
      end
`ifdef OFFSET_ARB_RR_EN
      favour_b = (w == 0);
`endif
      armed = w;
      arm_x = cur_x[w];
      arm_y = cur_y[w];
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("%s%0d_write", tag, i), 32'(ow[i]), 32'd0);
      check_output($sformatf("%s%0d_acka", tag, i), 32'(ack_a[i]), 32'd0);
      check_output($sformatf("%s%0d_ackb", tag, i), 32'(ack_b[i]), 32'd0);
      check_output($sformatf("%s%0d_busy", tag, i), 32'(busy[i]), 32'd0);
      check_output($sformatf("%s%0d_xdata", tag, i), 32'(xo[i]), 32'd0);
      check_output($sformatf("%s%0d_ydata", tag, i), 32'(yo[i]), 32'd0);
    end
  endtask

  // One frame: optional new requests in the low phase, a VSync pulse, then
  // either the commit window or a reset landing in WRITE.
  task automatic apply_stimulus(input bit ra, input logic [5:0] nxa, input logic [9:0] nya,
                                input bit rb, input logic [5:0] nxb, input logic [9:0] nyb,
                                input bit chg, input logic [5:0] cx, input logic [9:0] cy,
                                input bit rst_mid);
    int e0;
    for (int i = 0; i < 2; i++)
      check_output($sformatf("busy_frame_start%0d", i), 32'(busy[i]), 32'(armed >= 0));
    if (ra && !pend[0]) raise(0, nxa, nya);
    if (rb && !pend[1]) raise(1, nxb, nyb);
    arbitrate();
    wait_cycles(int'($urandom_range(8, 4)));
    vsync = 1'b1;
    if (chg && armed >= 0) drive(armed, cx, cy);
    wait_cycles(int'($urandom_range(6, 2)));
    vsync = 1'b0;
    e0 = cyc + 1;
    if (rst_mid) begin
      quiet = 1'b1;
      while (cyc < e0 + 2) wait_cycles(1);
      rst = 1'b1;
      wait_cycles(2);
      check_zero("reset_mid");
      rst = 1'b0;
      armed = -1;
`ifdef OFFSET_ARB_RR_EN
      favour_b = 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
        last_x[i] = '0;
        last_y[i] = '0;
      end
      arbitrate();
      wait_cycles(10);
      quiet = 1'b0;
    end else begin
      if (armed >= 0)
        for (int i = 0; i < 2; i++)
          expq[i].push_back('{src: armed, x: arm_x, y: arm_y, rise: e0 + settle_of(i) + 1});
      wait_cycles(12);
      if (armed >= 0) begin
        pend[armed] = 1'b0;
        armed = -1;
      end
      arbitrate();
    end
  endtask

  task automatic monitor(input int i);
    bit   prev_ow;
    bit   fall;
    bit   have;
    int   w;
    exp_t cur;
    prev_ow = 1'b0;
    have    = 1'b0;
    w       = 0;
    forever begin
      @(posedge clk);
      if (quiet) begin
        if (!$isunknown({ack_a[i], ack_b[i]}))
          check_output($sformatf("ack_during_reset%0d", i), 32'({ack_a[i], ack_b[i]}), 32'd0);
        prev_ow = 1'b0;
        have    = 1'b0;
        w       = 0;
      end else begin
        fall = prev_ow && !ow[i];
        if (ow[i] && !prev_ow) begin
          check_output($sformatf("write_expected%0d", i), 32'(expq[i].size() != 0), 32'd1);
          if (expq[i].size() != 0) begin
            cur  = expq[i].pop_front();
            have = 1'b1;
            check_output($sformatf("write_rise_cycle%0d", i), 32'(cyc), 32'(cur.rise));
            check_output($sformatf("xdata%0d", i), 32'(xo[i]), 32'(cur.x));
            check_output($sformatf("ydata%0d", i), 32'(yo[i]), 32'(cur.y));
          end
          w = 1;
        end else if (ow[i]) begin
          w++;
        end
        if (fall && have) begin
          check_output($sformatf("write_width%0d", i), 32'(w), 32'(wlen_of(i)));
          check_output($sformatf("ack_source%0d", i), 32'({ack_a[i], ack_b[i]}),
                       (cur.src == 1) ? 32'd1 : 32'd2);
          last_x[i] = cur.x;
          last_y[i] = cur.y;
          have = 1'b0;
        end else begin
          check_output($sformatf("ack_idle%0d", i), 32'({ack_a[i], ack_b[i]}), 32'd0);
          if (!ow[i] && !fall) begin
            check_output($sformatf("xdata_hold%0d", i), 32'(xo[i]), 32'(last_x[i]));
            check_output($sformatf("ydata_hold%0d", i), 32'(yo[i]), 32'(last_y[i]));
          end
        end
        prev_ow = ow[i];
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    #400000;
    $display("[TB] FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst   = 1'b1;
    vsync = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_a[i]  = 1'b0;
      req_b[i]  = 1'b0;
      xa[i]     = '0;
      xb[i]     = '0;
      ya[i]     = '0;
      yb[i]     = '0;
      last_x[i] = '0;
      last_y[i] = '0;
      pend[i]   = 1'b0;
      cur_x[i]  = '0;
      cur_y[i]  = '0;
    end
    repeat (3) @(posedge clk);
    check_zero("reset");
    rst   = 1'b0;
    quiet = 1'b0;

    $display("[TB] simultaneous requests over three frames");
    apply_stimulus(1, 6'd1, 10'd1, 1, 6'd2, 10'd2, 0, 6'd0, 10'd0, 0);
    apply_stimulus(1, 6'd1, 10'd1, 0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0);
    apply_stimulus(0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0);

    $display("[TB] single host request");
    apply_stimulus(1, 6'h2A, 10'h155, 0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0);

    $display("[TB] data change after grant");
    apply_stimulus(1, 6'd5, 10'h0C3, 0, 6'd0, 10'd0, 1, 6'd9, 10'h0C3, 0);

    $display("[TB] reset during write");
    apply_stimulus(1, 6'h11, 10'h222, 0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 1);
    apply_stimulus(0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++)
      apply_stimulus(1'($urandom_range(1, 0)), 6'($urandom), 10'($urandom),
                     1'($urandom_range(1, 0)), 6'($urandom), 10'($urandom),
                     $urandom_range(3, 0) == 0, 6'($urandom), 10'($urandom),
                     (f % 13) == 7);

    for (int f = 0; f < 3; f++)
      apply_stimulus(0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0, 6'd0, 10'd0, 0);

    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("commits_outstanding%0d", i), 32'(expq[i].size()), 32'd0);
      check_output($sformatf("busy_end%0d", i), 32'(busy[i]), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/offset_commit_arbiter.md
# offset_commit_arbiter

Sequencer and arbiter for the scroll-offset register. Two requesters, a host port A and an auto-scroll port B, each submit a 6-bit X and 10-bit Y offset. The block grants one request at a time and holds the granted values in a shadow register. It commits them with an `OffsetWrite` pulse only after a full VSync high phase ends, so the visible frame never tears. It replaces direct drive of `XOffsetData`/`YOffsetData`/`OffsetWrite` by any single generator.

## Interface
- `SETTLE_CYC`, default 1: cycles between sampling VSync low and the start of `OffsetWrite`; range 0..15.
- `WRITE_LEN`, default 1: width of the `OffsetWrite` pulse in cycles; range 1..15.

- `PixelClk2`  in  1  clock; all registers update on its falling edge.
- `Reset`  in  1  synchronous, active-high reset, sampled on the falling edge of `PixelClk2`.
- `VSync`  in  1  vertical sync, active high, already synchronous to `PixelClk2`.
- `ReqA`  in  1  host request; held high with `XA`/`YA` stable until `AckA`.
- `XA`  in  6  host X offset.
- `YA`  in  10  host Y offset.
- `AckA`  out  1  one-cycle pulse: host value committed.
- `ReqB`  in  1  auto-scroll request; same rules as `ReqA`.
- `XB`  in  6  auto-scroll X offset.
- `YB`  in  10  auto-scroll Y offset.
- `AckB`  out  1  one-cycle pulse: auto-scroll value committed.
- `XOffsetData`  out  6  committed X offset; holds its value between commits.
- `YOffsetData`  out  10  committed Y offset; holds its value between commits.
- `OffsetWrite`  out  1  write strobe to the offset register.
- `Busy`  out  1  high in every state except IDLE.

## Operation
States and transitions:
- **IDLE**
  - If `ReqA` or `ReqB` is sampled high, grant one requester per the priority rule, latch its X/Y into the shadow register and go to ARMED.
  - Otherwise stay in IDLE.
- **ARMED**: go to VS_HI when `VSync`=1. If `VSync` is already high at grant, that high phase counts.
- **VS_HI**: when `VSync`=0, go to SETTLE; if `SETTLE_CYC`=0, go directly to WRITE.
- **SETTLE**: count `SETTLE_CYC` cycles, then go to WRITE.
- **WRITE**
  - On entry, `XOffsetData`/`YOffsetData` load from the shadow register and `OffsetWrite`=1.
  - The state lasts `WRITE_LEN` cycles, then goes to DONE.
- **DONE**: `OffsetWrite`=0; the granted requester's Ack is 1 for exactly one cycle; go to HOLDOFF.
- **HOLDOFF**: one cycle with `Req` ignored, so the requester can drop `Req`; then go to IDLE.

Rules:
- Shadow data is captured only at grant. Changes on X/Y after grant are ignored.
- The requester that is not granted keeps waiting; its `Req` is not lost and is served on a later frame.
- At most one commit occurs per VSync high→low transition.
- Widths are fixed and there is no arithmetic on offsets: values pass through unmodified.

Reset (synchronous, any state, including mid-WRITE):
- State → IDLE.
- `XOffsetData`=0, `YOffsetData`=0, `OffsetWrite`=0, `AckA`=`AckB`=0, `Busy`=0.
- Shadow register = 0; round-robin pointer favours A.
- An in-flight request is dropped without Ack. The requester keeps `Req` high and is re-granted after reset.

## Timing
- Let E0 be the falling edge at which VS_HI samples `VSync`=0.
- `OffsetWrite` rises and the data updates at E0+`SETTLE_CYC`+1. Default: E0+2.
- `OffsetWrite` falls and Ack rises at E0+`SETTLE_CYC`+1+`WRITE_LEN`.
- Ack falls one cycle later; IDLE is re-entered two cycles after Ack rises.
- Grant latency: one cycle after `Req` is sampled in IDLE.
- Minimum spacing between back-to-back commits is one frame.
- A `VSync` pulse that ends while the block is in IDLE or ARMED without having been seen high is not used.

## Configuration
- **`OFFSET_ARB_RR_EN` defined**
  - Round-robin arbitration: with both requests high in IDLE, grant the requester not granted last.
  - The pointer updates at each grant; after reset, A wins the first tie.
- **`OFFSET_ARB_RR_EN` undefined**
  - Fixed priority: A always wins a tie.
  - B is starved while `ReqA` stays high.

## Test plan
- **Reset values**: assert `Reset` for 2 cycles → all outputs 0, `Busy`=0.
- **Single host request**
  - Stimulus: `ReqA` with `XA`=6'h2A, `YA`=10'h155 while `VSync`=0; then one VSync high/low pulse; default parameters.
  - Response: `XOffsetData`=6'h2A, `YOffsetData`=10'h155, with `OffsetWrite` high for 1 cycle at E0+2.
  - Response: `AckA` at E0+3; `AckB` never pulses.
- **Simultaneous requests**
  - Stimulus: `ReqA` (X=1, Y=1) and `ReqB` (X=2, Y=2) held high across 3 frames.
  - Response, fixed priority: A commits on frame 1 and B commits on frame 2.
  - Response, `OFFSET_ARB_RR_EN`: A commits first, then B, then A; an A-then-B order is required in both builds.
- **Parameter variants**: `SETTLE_CYC`=0, `WRITE_LEN`=3 → `OffsetWrite` high at E0+1..E0+3 and Ack at E0+4.
- **Data change after grant**: change `XA` from 5 to 9 after grant → 5 is committed.
- **Reset mid-operation**: assert `Reset` during WRITE → outputs return to 0 and no Ack is issued; with `ReqA` still high, the request is re-granted and committed on the next frame.
